// File: rtl/bcd_share_ctrl.sv
// Round-robin shared 32-bit binary-to-BCD converter (double dabble, one shift per clock).
// Latency: grant on the sampling edge E0, done/bcd_out/ovf on E33, back in IDLE at E34 (35-cycle period).
// Backpressure: requesters hold req (and operand) until done; losers simply wait in round-robin order.
module bcd_share_ctrl #(
   parameter int N_REQ = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [32*N_REQ-1:0]  bin_in,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     done,
   output logic [31:0]          bcd_out,
   output logic                 ovf,
   output logic                 busy
);

   localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [71:0]     sr;       // [71:32] = 10 BCD digits, [31:0] = binary operand being shifted out
   logic [71:0]     sr_adj;
   logic [5:0]      cnt;
   logic [LW-1:0]   last;     // index served most recently; search starts just after it
   logic [LW-1:0]   gidx;     // index currently being served
   logic [LW-1:0]   sel;
   logic            sel_vld;
   logic [N_REQ-1:0] one_hot_base;

   assign one_hot_base = {{(N_REQ-1){1'b0}}, 1'b1};
   assign busy         = (state != IDLE);

   // Round-robin pick: first active req scanning last+1, last+2, ... modulo N_REQ.
   always_comb begin : arb
      int idx;
      idx     = 0;
      sel     = '0;
      sel_vld = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = (int'(last) + i) % N_REQ;
         if (!sel_vld && req[idx]) begin
            sel_vld = 1'b1;
            sel     = LW'(idx);
         end
      end
   end

   // Double-dabble correction: +3 on every digit above 4, all digits judged on the pre-adjust value.
   always_comb begin
      sr_adj = sr;
      for (int d = 0; d < 10; d++) begin
         if (sr[32+4*d +: 4] > 4'd4) begin
            sr_adj[32+4*d +: 4] = sr[32+4*d +: 4] + 4'd3;
         end
      end
   end

   // Next-state logic: one grant per IDLE cycle, 32 shifts plus the result edge, one DONE cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_vld) state_nxt = SHIFT;
         SHIFT:   if (cnt == 6'd32) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset discards any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: latch operand on grant, shift while counting, publish result on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         cnt     <= '0;
         last    <= LW'(N_REQ-1);
         gidx    <= '0;
         grant   <= '0;
         done    <= '0;
         bcd_out <= '0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  sr    <= {40'd0, bin_in[32*int'(sel) +: 32]};
                  cnt   <= '0;
                  gidx  <= sel;
                  grant <= one_hot_base << sel;
               end
            end
            SHIFT: begin
               if (cnt == 6'd32) begin
                  bcd_out <= sr[63:32];
                  ovf     <= |sr[71:64];
                  done    <= grant;
                  last    <= gidx;
               end else begin
                  sr  <= sr_adj << 1;
                  cnt <= cnt + 6'd1;
               end
            end
            DONE: begin
               grant <= '0;
               done  <= '0;
            end
            default: begin
               grant <= '0;
               done  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_share_ctrl.sv
// Directed bench for bcd_share_ctrl: reset values, boundary conversions, round-robin order,
// persistence, operand latching and reset mid-conversion; expected values written by hand.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_bcd_share_ctrl;

   localparam int N = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [32*N-1:0] bin_in;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic [31:0]     bcd_out;
   logic            ovf;
   logic            busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bcd_share_ctrl #(.N_REQ(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .bin_in  (bin_in),
      .grant   (grant),
      .done    (done),
      .bcd_out (bcd_out),
      .ovf     (ovf),
      .busy    (busy)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Free-running cycle count used to measure spacing between done pulses.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, output int at);
      bit seen;
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
         step();
         if (done != '0) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      chk({tag, "_timeout"}, 64'(seen), 64'd1);
   endtask

   // One isolated conversion on requester k with exact edge-by-edge timing checks.
   task automatic single(input int k, input logic [31:0] val, input logic [31:0] exp_bcd,
                         input logic exp_ovf, input string tag);
      bin_in[32*k +: 32] = val;
      req[k] = 1'b1;
      step();                                   // E0
      chk({tag, "_grant"}, 64'(grant), 64'd1 << k);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      repeat (32) step();                       // E32
      chk({tag, "_nodone_e32"}, 64'(done), 64'd0);
      step();                                   // E33
      chk({tag, "_done"}, 64'(done), 64'd1 << k);
      chk({tag, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
      chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
      req[k] = 1'b0;
      step();                                   // E34
      chk({tag, "_done_clr"}, 64'(done), 64'd0);
      chk({tag, "_grant_clr"}, 64'(grant), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   // Directed sequence.
   initial begin
      int at;
      int t_prev;
      logic [31:0] exp_v;

      rst_n  = 1'b0;
      req    = '0;
      bin_in = '0;
      #2;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_bcd", 64'(bcd_out), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      #10 rst_n = 1'b1;
      step();
      chk("idle_no_req", 64'(busy), 64'd0);

      single(0, 32'd12345678, 32'h12345678, 1'b0, "single0");
      single(1, 32'd0,          32'h00000000, 1'b0, "zero");
      single(1, 32'd99999999,   32'h99999999, 1'b0, "max8");
      single(1, 32'd100000000,  32'h00000000, 1'b1, "ovf9");
      single(1, 32'd4294967295, 32'h94967295, 1'b1, "max32");

      // Operand latched at grant: a later slice change must not leak in.
      bin_in[64 +: 32] = 32'd500;
      req[2] = 1'b1;
      step();                                   // E0
      chk("opchg_grant", 64'(grant), 64'd4);
      repeat (5) step();                        // E5
      bin_in[64 +: 32] = 32'd777;
      repeat (27) step();                       // E32
      step();                                   // E33
      chk("opchg_done", 64'(done), 64'd4);
      chk("opchg_bcd", 64'(bcd_out), 64'h500);
      req[2] = 1'b0;
      step();

      // All three together, last = 2: served 0, 1, 2, 35 cycles apart.
      bin_in[0  +: 32] = 32'd11;
      bin_in[32 +: 32] = 32'd22;
      bin_in[64 +: 32] = 32'd33;
      req    = 3'b111;
      t_prev = 0;
      for (int n = 0; n < 3; n++) begin
         wait_done("rr3", at);
         exp_v = (n == 0) ? 32'h11 : (n == 1) ? 32'h22 : 32'h33;
         chk("rr3_order", 64'(done), 64'd1 << n);
         chk("rr3_bcd", 64'(bcd_out), 64'(exp_v));
         if (n > 0) chk("rr3_spacing", 64'(at - t_prev), 64'd35);
         t_prev = at;
         req[n] = 1'b0;
      end

      // req 0 and 2 together with last = 2: requester 0 first.
      bin_in[0  +: 32] = 32'd7;
      bin_in[64 +: 32] = 32'd9;
      req = 3'b101;
      wait_done("rr2a", at);
      chk("rr2_first", 64'(done), 64'd1);
      chk("rr2_first_bcd", 64'(bcd_out), 64'h7);
      req[0] = 1'b0;
      wait_done("rr2b", at);
      chk("rr2_second", 64'(done), 64'd4);
      chk("rr2_second_bcd", 64'(bcd_out), 64'h9);
      req[2] = 1'b0;

      // req 1 held high while req 0 pulses: grants alternate 0,1,0,1.
      bin_in[0  +: 32] = 32'd5;
      bin_in[32 +: 32] = 32'd6;
      req = 3'b011;
      for (int n = 0; n < 4; n++) begin
         wait_done("pers", at);
         if (n % 2 == 0) begin
            chk("pers_order", 64'(done), 64'd1);
            chk("pers_bcd", 64'(bcd_out), 64'h5);
            req[0] = 1'b0;
         end else begin
            chk("pers_order", 64'(done), 64'd2);
            chk("pers_bcd", 64'(bcd_out), 64'h6);
            req[0] = 1'b1;
         end
      end
      req = '0;
      step();
      step();

      // Reset at E10 of a conversion, then the held request completes after re-grant.
      bin_in[0 +: 32] = 32'd42;
      req[0] = 1'b1;
      step();                                   // E0
      chk("mrst_grant", 64'(grant), 64'd1);
      repeat (10) step();                       // E10
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_grant0", 64'(grant), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_bcd", 64'(bcd_out), 64'd0);
      chk("mrst_ovf", 64'(ovf), 64'd0);
      step();
      step();
      chk("mrst_hold_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      step();                                   // re-grant edge
      chk("mrst_regrant", 64'(grant), 64'd1);
      repeat (32) step();
      chk("mrst_nodone", 64'(done), 64'd0);
      step();
      chk("mrst_done_after", 64'(done), 64'd1);
      chk("mrst_bcd_after", 64'(bcd_out), 64'h42);
      chk("mrst_ovf_after", 64'(ovf), 64'd0);
      req = '0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
